// File: rtl/lfsr_encrypt_engine_if.sv
// rtl/lfsr_encrypt_engine_if.sv - start handshake and data-memory port of the LFSR encrypt engine
//
// Purpose: bundles the req/ack launch handshake with the DM master port.
// Signals:
//   req          start request (level), from top level
//   ack          run complete, to top level
//   mem_addr     DM address (8 bits)
//   mem_rd_data  DM read data, valid one cycle after mem_addr
//   mem_wr_en    DM write strobe
//   mem_wr_data  DM write data
// Modports: master = the engine (drives DM), slave = top level / memory side.
interface lfsr_encrypt_engine_if;
  logic       req;
  logic       ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (
    input  req,
    input  mem_rd_data,
    output ack,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );

  modport slave (
    output req,
    output mem_rd_data,
    input  ack,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );
endinterface

// File: rtl/lfsr_encrypt_engine.sv
// rtl/lfsr_encrypt_engine.sv - builds a space-padded 64-byte frame and LFSR-encrypts it into DM[64..127]
//
// Purpose: reads preamble length, tap mask and LFSR seed from DM[61..63], then
// emits FRAME_LEN bytes: preamble of 0x20 pads followed by message bytes from
// DM[0..], each XORed with a 7-bit LFSR, written at CRYPT_BASE+i.
// Ports:
//   clk     system clock, rising edge
//   init_n  asynchronous active-low reset
//   bus     lfsr_encrypt_engine_if.master (req/ack handshake + DM port)
// Optional feature macro: LFSR_ENC_PARITY_EN
//   defined   -> bit 7 of each encrypted byte is the parity of bits 6:0
//   undefined -> bit 7 is 0
module lfsr_encrypt_engine #(
  parameter int FRAME_LEN  = 64,
  parameter int CRYPT_BASE = 64,
  parameter int PRE_MIN    = 10,
  parameter int PRE_MAX    = 26
) (
  input  logic                  clk,
  input  logic                  init_n,
  lfsr_encrypt_engine_if.master bus
);

  localparam logic [7:0] ADDR_PRE   = 8'd61;
  localparam logic [7:0] ADDR_TAPS  = 8'd62;
  localparam logic [7:0] ADDR_SEED  = 8'd63;
  localparam logic [7:0] PRE_MIN_B  = 8'(PRE_MIN);
  localparam logic [7:0] PRE_MAX_B  = 8'(PRE_MAX);
  localparam logic [7:0] LAST_IDX   = 8'(FRAME_LEN - 1);
  localparam logic [7:0] CRYPT_B    = 8'(CRYPT_BASE);

  typedef enum logic [2:0] {
    IDLE, CFG0, CFG1, CFG2, CFG3, RD, WR, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] pre_q, pre_d;
  logic [6:0] taps_q, taps_d;
  logic [6:0] lfsr_q, lfsr_d;

  logic [6:0] plain_lo;
  logic [6:0] cipher_lo;
  logic [7:0] cipher;

  // State and datapath registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      pre_q   <= '0;
      taps_q  <= '0;
      lfsr_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Encryption of the current byte; pads are taken while i is inside the preamble.
  always_comb begin
    plain_lo  = (i_q < pre_q) ? 7'h20 : bus.mem_rd_data[6:0];
    cipher_lo = plain_lo ^ lfsr_q;
`ifdef LFSR_ENC_PARITY_EN
    cipher    = {^cipher_lo, cipher_lo};
`else
    cipher    = {1'b0, cipher_lo};
`endif
  end

  // Next-state and datapath update. Each config read lands one state after
  // its address is presented, so CFGn consumes the byte addressed in CFG(n-1).
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    pre_d   = pre_q;
    taps_d  = taps_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      IDLE: if (bus.req) state_d = CFG0;
      CFG0: state_d = CFG1;
      CFG1: begin
        if (bus.mem_rd_data < PRE_MIN_B)      pre_d = PRE_MIN_B;
        else if (bus.mem_rd_data > PRE_MAX_B) pre_d = PRE_MAX_B;
        else                                  pre_d = bus.mem_rd_data;
        state_d = CFG2;
      end
      CFG2: begin
        taps_d  = bus.mem_rd_data[6:0];
        state_d = CFG3;
      end
      CFG3: begin
        // An all-zero LFSR would lock up, so a zero seed is forced to 1.
        lfsr_d  = (bus.mem_rd_data[6:0] == 7'd0) ? 7'h01 : bus.mem_rd_data[6:0];
        i_d     = '0;
        state_d = RD;
      end
      RD: state_d = WR;
      WR: begin
        lfsr_d  = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
        i_d     = i_q + 8'd1;
        state_d = (i_q == LAST_IDX) ? DONE : RD;
      end
      DONE: if (!bus.req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    bus.ack         = 1'b0;
    bus.mem_addr    = 8'd0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 8'd0;
    case (state_q)
      CFG0: bus.mem_addr = ADDR_PRE;
      CFG1: bus.mem_addr = ADDR_TAPS;
      CFG2: bus.mem_addr = ADDR_SEED;
      RD:   if (i_q >= pre_q) bus.mem_addr = i_q - pre_q;
      WR: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = CRYPT_B + i_q;
        bus.mem_wr_data = cipher;
      end
      DONE: bus.ack = 1'b1;
      default: ;
    endcase
  end

endmodule
